pa_cp0_lpmd_seq: RTL and testbench
==================================

PA_CP0_LPMD_SEQ -- requirements
Module: pa_cp0_lpmd_seq

Interface
REQ-001 Parameter NUM_ACK, default 2: number of request/acknowledge channels (IFU, LSU, ...), range 1..8.
REQ-002 Parameter MODE_W, default 2: low-power mode width; all-ones means "no low power".
REQ-003 Parameter TO_W, default 8: acknowledge-timeout counter width.
REQ-004 Parameter EXIT_CYC, default 4: exit-settle cycles, range 1..2^TO_W-1.
REQ-005 forever_cpuclk  in  1  single clock; all state updates on its rising edge.
REQ-006 cpurst  in  1  reset, synchronous, active-high.
REQ-007 iui_special_wfi  in  1  WFI valid; held until special_iui_stall deasserts.
REQ-008 regs_special_lpmd  in  MODE_W  requested mode; sampled on REQ->LPMD.
REQ-009 regs_special_timeout  in  TO_W  ack timeout in cycles; 0 disables the timeout.
REQ-010 ack_vec  in  NUM_ACK  per-channel acknowledge, level or pulse.
REQ-011 wake_req  in  1  interrupt/wake-up pending.
REQ-012 dbg_on  in  1  debug entry; forces exit.
REQ-013 rtu_yy_xx_flush  in  1  pipeline flush.
REQ-014 lpmd_req_vec  out  NUM_ACK  per-channel low-power request.
REQ-015 lpmd_b  out  MODE_W  active-low mode to sysio; all-ones = running.
REQ-016 in_lpmd  out  1  core in low power.
REQ-017 cp0_yy_clk_en  out  1  global clock enable = !in_lpmd.
REQ-018 special_iui_stall  out  1  stall the WFI in IUI.
REQ-019 special_iui_abort  out  1  one-cycle pulse on timeout abort.
REQ-020 lpmd_top_cur_state  out  3  FSM state, debug only.

Function
REQ-021 States: IDLE=000, REQ=001, LPMD=011, EXIT=010, CPLT=100; all other encodings go to IDLE.
REQ-022 IDLE: wfi && regs_special_lpmd != all-ones -> REQ; on this transition sticky acks clear and the timeout counter loads regs_special_timeout. wfi && lpmd == all-ones -> CPLT. Otherwise stay in IDLE.
REQ-023 REQ: sticky[i] sets when ack_vec[i]=1. lpmd_req_vec[i] = (state==REQ) && !sticky[i]; a channel's request drops the cycle after its ack.
REQ-024 REQ priority 1: wake_req || dbg_on -> CPLT; lpmd_b stays all-ones; no abort pulse.
REQ-025 REQ priority 2: (sticky | ack_vec) all-ones -> LPMD; lpmd_b <= regs_special_lpmd in the same edge.
REQ-026 REQ priority 3: timeout != 0 && counter == 1 with acks incomplete -> CPLT; special_iui_abort pulses during the CPLT cycle.
REQ-027 REQ otherwise: stay in REQ; the counter decrements while nonzero.
REQ-028 LPMD: in_lpmd=1 and cp0_yy_clk_en=0. wake_req || dbg_on -> EXIT; lpmd_b <= all-ones; the counter loads EXIT_CYC.
REQ-029 EXIT: the counter decrements each cycle; at 1 -> CPLT. in_lpmd=0 throughout EXIT.
REQ-030 CPLT: lasts one cycle, then -> IDLE.
REQ-031 special_iui_stall = (IDLE && wfi) || REQ || LPMD || EXIT; it is 0 in CPLT, which releases the WFI.
REQ-032 rtu_yy_xx_flush in REQ, EXIT or CPLT -> IDLE next cycle; sticky acks clear; lpmd_b <= all-ones; no abort pulse.
REQ-033 rtu_yy_xx_flush is ignored in LPMD.
REQ-034 When flush and wake_req arrive in the same REQ cycle, flush wins.
REQ-035 Latency with all acks in the first REQ cycle and lpmd != all-ones: wfi@IDLE at cycle 0, REQ at 1, LPMD at 2.
REQ-036 Latency, wake to release: wake@LPMD at cycle n, EXIT from n+1 to n+EXIT_CYC, CPLT at n+EXIT_CYC+1.

Reset
REQ-037 cpurst=1 at a clock edge sets: state=IDLE, sticky=0, counter=0, lpmd_b=all-ones, lpmd_req_vec=0, in_lpmd=0, cp0_yy_clk_en=1, special_iui_stall=0 (unless IDLE&&wfi), special_iui_abort=0.
REQ-038 Reset applies from any state, including LPMD.

Structure
REQ-039 The state encodings and MODE_W/TO_W defaults live in shared package pa_cp0_pkg.
REQ-040 A single sub-module, pa_cp0_ack_collect, holds the NUM_ACK sticky-ack register and the all-acked reduction.
REQ-041 Outputs are combinational from state/sticky, except lpmd_b, which is a register.

Verification
REQ-042 Scenario, simple entry and exit: NUM_ACK=2, lpmd=2'b10; wfi, acks at cycles 1 and 3 -> LPMD at 4, lpmd_b=10; wake at 10 -> EXIT 11-14, CPLT at 15, stall drops at 15.
REQ-043 Scenario, ack timeout: timeout=5; only ack_vec[0] asserted -> CPLT 5 cycles after REQ entry, abort pulse 1 cycle, lpmd_b stays 11.
REQ-044 Scenario, wake during REQ: wake at 2nd REQ cycle -> CPLT next; lpmd_b never leaves 11; in_lpmd=0.
REQ-045 Scenario, NOP WFI: lpmd=11 -> IDLE->CPLT->IDLE; lpmd_req_vec never asserted.
REQ-046 Scenario, flush precedence: flush and wake together in REQ -> IDLE next cycle, no abort.
REQ-047 Scenario, reset in LPMD: cpurst=1 in LPMD -> next cycle IDLE, lpmd_b=11, clk_en=1.

Source files
------------

// File: rtl/pa_cp0_pkg.sv
// Shared state encodings and width defaults for the CP0 low-power-mode sequencer.
package pa_cp0_pkg;

  localparam int MODE_W_DEF = 2;
  localparam int TO_W_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_REQ  = 3'b001,
    ST_LPMD = 3'b011,
    ST_EXIT = 3'b010,
    ST_CPLT = 3'b100
  } lpmd_state_e;

endpackage

// File: rtl/pa_cp0_lpmd_seq_if.sv
// WFI stall handshake with IUI plus the per-channel low-power request/acknowledge bundle.
interface pa_cp0_lpmd_seq_if #(
  parameter int NUM_ACK = 2
) ();

  // iui_special_wfi is held valid until special_iui_stall drops (CPLT releases it);
  // lpmd_req_vec[i] stays high until ack_vec[i] is seen, as a level or a one-cycle pulse.
  logic               iui_special_wfi;
  logic               special_iui_stall;
  logic               special_iui_abort;
  logic [NUM_ACK-1:0] lpmd_req_vec;
  logic [NUM_ACK-1:0] ack_vec;

  modport master (
    input  iui_special_wfi,
    input  ack_vec,
    output special_iui_stall,
    output special_iui_abort,
    output lpmd_req_vec
  );

  modport slave (
    output iui_special_wfi,
    output ack_vec,
    input  special_iui_stall,
    input  special_iui_abort,
    input  lpmd_req_vec
  );

endinterface

// File: rtl/pa_cp0_ack_collect.sv
// Sticky per-channel acknowledge register and the all-acknowledged reduction.
module pa_cp0_ack_collect
  import pa_cp0_pkg::*;
#(
  parameter int NUM_ACK = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [NUM_ACK-1:0] ack_vec,
  output logic [NUM_ACK-1:0] sticky,
  output logic               all_acked
);

  logic [NUM_ACK-1:0] sticky_d;
  logic [NUM_ACK-1:0] sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (clr) begin
      sticky_d = '0;
    end else if (en) begin
      sticky_d = sticky_q | ack_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // A channel acking in the current cycle counts, so a single-cycle pulse is enough.
  assign sticky    = sticky_q;
  assign all_acked = &(sticky_q | ack_vec);

endmodule

// File: rtl/pa_cp0_lpmd_seq.sv
// Low-power-mode sequencer: collects channel acks after WFI, enters/exits low power, releases WFI.
module pa_cp0_lpmd_seq
  import pa_cp0_pkg::*;
#(
  parameter int NUM_ACK  = 2,
  parameter int MODE_W   = MODE_W_DEF,
  parameter int TO_W     = TO_W_DEF,
  parameter int EXIT_CYC = 4
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  pa_cp0_lpmd_seq_if.master lpmd_if,
  input  logic [MODE_W-1:0] regs_special_lpmd,
  input  logic [TO_W-1:0]   regs_special_timeout,
  input  logic              wake_req,
  input  logic              dbg_on,
  input  logic              rtu_yy_xx_flush,
  output logic [MODE_W-1:0] lpmd_b,
  output logic              in_lpmd,
  output logic              cp0_yy_clk_en,
  output logic [2:0]        lpmd_top_cur_state
);

  localparam logic [MODE_W-1:0] MODE_RUN = '1;
  localparam logic [TO_W-1:0]   CNT_ONE  = TO_W'(1);

  lpmd_state_e        state_d, state_q;
  logic [TO_W-1:0]    cnt_d, cnt_q;
  logic [MODE_W-1:0]  lpmd_b_d, lpmd_b_q;
  logic               abort_d, abort_q;
  logic               ack_clr;
  logic               wake;
  logic               wfi;
  logic [NUM_ACK-1:0] sticky;
  logic               all_acked;

  assign wfi  = lpmd_if.iui_special_wfi;
  assign wake = wake_req | dbg_on;

  pa_cp0_ack_collect #(
    .NUM_ACK (NUM_ACK)
  ) u_ack_collect (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .clr       (ack_clr),
    .en        (state_q == ST_REQ),
    .ack_vec   (lpmd_if.ack_vec),
    .sticky    (sticky),
    .all_acked (all_acked)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lpmd_b_d = lpmd_b_q;
    abort_d  = 1'b0;
    ack_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wfi) begin
          if (regs_special_lpmd != MODE_RUN) begin
            state_d = ST_REQ;
            ack_clr = 1'b1;
            cnt_d   = regs_special_timeout;
          end else begin
            state_d = ST_CPLT;
          end
        end
      end
      // Flush beats wake, wake beats a completed ack set, which beats the timeout.
      ST_REQ: begin
        if (rtu_yy_xx_flush) begin
          state_d  = ST_IDLE;
          ack_clr  = 1'b1;
          lpmd_b_d = MODE_RUN;
        end else if (wake) begin
          state_d = ST_CPLT;
        end else if (all_acked) begin
          state_d  = ST_LPMD;
          lpmd_b_d = regs_special_lpmd;
        end else if ((regs_special_timeout != '0) && (cnt_q == CNT_ONE)) begin
          state_d = ST_CPLT;
          abort_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_LPMD: begin
        if (wake) begin
          state_d  = ST_EXIT;
          lpmd_b_d = MODE_RUN;
          cnt_d    = TO_W'(EXIT_CYC);
        end
      end
      ST_EXIT: begin
        if (rtu_yy_xx_flush) begin
          state_d  = ST_IDLE;
          ack_clr  = 1'b1;
          lpmd_b_d = MODE_RUN;
        end else begin
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_CPLT;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_CPLT: begin
        state_d = ST_IDLE;
        if (rtu_yy_xx_flush) begin
          ack_clr  = 1'b1;
          lpmd_b_d = MODE_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      lpmd_b_q <= MODE_RUN;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lpmd_b_q <= lpmd_b_d;
      abort_q  <= abort_d;
    end
  end

  // abort_q marks a CPLT reached by timeout; CPLT lasts one cycle, so the abort is a pulse.
  assign lpmd_if.lpmd_req_vec      = {NUM_ACK{state_q == ST_REQ}} & ~sticky;
  assign lpmd_if.special_iui_stall = ((state_q == ST_IDLE) && wfi) || (state_q == ST_REQ) ||
                                     (state_q == ST_LPMD) || (state_q == ST_EXIT);
  assign lpmd_if.special_iui_abort = (state_q == ST_CPLT) && abort_q;
  assign in_lpmd                   = (state_q == ST_LPMD);
  assign cp0_yy_clk_en             = ~in_lpmd;
  assign lpmd_b                    = lpmd_b_q;
  assign lpmd_top_cur_state        = state_q;

endmodule

// File: tb/tb_pa_cp0_lpmd_seq.sv
// Bench for pa_cp0_lpmd_seq: directed scenarios plus randomized WFI sequences against a timeline model.
module tb_pa_cp0_lpmd_seq;

  localparam int NUM_ACK  = 2;
  localparam int MODE_W   = 2;
  localparam int TO_W     = 8;
  localparam int EXIT_CYC = 4;
  localparam int NEVER    = 1000;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_REQ  = 3'b001;
  localparam logic [2:0] S_LPMD = 3'b011;
  localparam logic [2:0] S_EXIT = 3'b010;
  localparam logic [2:0] S_CPLT = 3'b100;

  localparam int OUT_NOP   = 0;
  localparam int OUT_WAKE  = 1;
  localparam int OUT_LPMD  = 2;
  localparam int OUT_ABORT = 3;

  logic              clk = 1'b0;
  logic              cpurst;
  logic [MODE_W-1:0] regs_lpmd;
  logic [TO_W-1:0]   regs_timeout;
  logic              wake_req;
  logic              dbg_on;
  logic              flush;
  logic [MODE_W-1:0] lpmd_b;
  logic              in_lpmd;
  logic              clk_en;
  logic [2:0]        cur_state;

  int n_checks = 0;
  int n_errors = 0;

  pa_cp0_lpmd_seq_if #(.NUM_ACK(NUM_ACK)) lpmd_if ();

  pa_cp0_lpmd_seq #(
    .NUM_ACK  (NUM_ACK),
    .MODE_W   (MODE_W),
    .TO_W     (TO_W),
    .EXIT_CYC (EXIT_CYC)
  ) dut (
    .forever_cpuclk       (clk),
    .cpurst               (cpurst),
    .lpmd_if              (lpmd_if),
    .regs_special_lpmd    (regs_lpmd),
    .regs_special_timeout (regs_timeout),
    .wake_req             (wake_req),
    .dbg_on               (dbg_on),
    .rtu_yy_xx_flush      (flush),
    .lpmd_b               (lpmd_b),
    .in_lpmd              (in_lpmd),
    .cp0_yy_clk_en        (clk_en),
    .lpmd_top_cur_state   (cur_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lpmd_if.iui_special_wfi = 1'b0;
    lpmd_if.ack_vec         = '0;
    wake_req                = 1'b0;
    dbg_on                  = 1'b0;
    flush                   = 1'b0;
  endtask

  task automatic test_reset();
    cpurst       = 1'b1;
    idle_inputs();
    regs_lpmd    = 2'b01;
    regs_timeout = 8'd0;
    step();
    step();
    #1;
    n_checks += 7;
    if (cur_state !== S_IDLE) begin n_errors++; $display("FAIL reset_state got %b exp %b", cur_state, S_IDLE); end
    if (lpmd_b !== 2'b11) begin n_errors++; $display("FAIL reset_lpmd_b got %b exp 11", lpmd_b); end
    if (in_lpmd !== 1'b0) begin n_errors++; $display("FAIL reset_in_lpmd got %b exp 0", in_lpmd); end
    if (clk_en !== 1'b1) begin n_errors++; $display("FAIL reset_clk_en got %b exp 1", clk_en); end
    if (lpmd_if.special_iui_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b exp 0", lpmd_if.special_iui_stall); end
    if (lpmd_if.special_iui_abort !== 1'b0) begin n_errors++; $display("FAIL reset_abort got %b exp 0", lpmd_if.special_iui_abort); end
    if (lpmd_if.lpmd_req_vec !== 2'b00) begin n_errors++; $display("FAIL reset_req_vec got %b exp 00", lpmd_if.lpmd_req_vec); end
    lpmd_if.iui_special_wfi = 1'b1;
    #1;
    n_checks++;
    if (lpmd_if.special_iui_stall !== 1'b1) begin n_errors++; $display("FAIL reset_wfi_stall got %b exp 1", lpmd_if.special_iui_stall); end
    step();
    n_checks++;
    if (cur_state !== S_IDLE) begin n_errors++; $display("FAIL reset_hold_state got %b exp %b", cur_state, S_IDLE); end
    lpmd_if.iui_special_wfi = 1'b0;
    cpurst = 1'b0;
    step();
  endtask

  // Timeline model: derive the cycle at which each phase ends from ack/wake/timeout arrival
  // times, then check every output each cycle. Cycle 0 is the IDLE cycle that sees WFI.
  task automatic test_scenario(input string name, input logic [1:0] mode, input int timeout,
                               input int a0, input int a1, input int w_req, input int m_lpmd,
                               input bit use_dbg);
    int a [2];
    bit lvl [2];
    int done_ack, lim, end_k, outcome, req_end, w_c, cplt_c, idle_c, k;
    logic [2:0] es;
    logic [1:0] e_req, e_lpmd_b;
    logic       e_stall, e_abort, e_in, wake_now;
    a[0] = a0;
    a[1] = a1;
    lvl[0] = 1'($urandom_range(0, 1));
    lvl[1] = 1'($urandom_range(0, 1));
    done_ack = (a0 > a1) ? a0 : a1;
    lim      = (timeout != 0) ? timeout - 1 : (1 << 20);
    end_k = 0; req_end = 0; w_c = 0;
    if (mode == 2'b11) outcome = OUT_NOP;
    else if (w_req >= 0 && w_req <= done_ack && w_req <= lim) begin outcome = OUT_WAKE; end_k = w_req; end
    else if (done_ack <= lim) begin outcome = OUT_LPMD; end_k = done_ack; end
    else begin outcome = OUT_ABORT; end_k = lim; end
    if (outcome == OUT_NOP) cplt_c = 1;
    else begin
      req_end = 1 + end_k;
      if (outcome == OUT_LPMD) begin
        w_c    = req_end + 1 + m_lpmd;
        cplt_c = w_c + EXIT_CYC + 1;
      end else cplt_c = req_end + 1;
    end
    idle_c       = cplt_c + 1;
    regs_lpmd    = mode;
    regs_timeout = TO_W'(timeout);
    for (int c = 0; c <= idle_c; c++) begin
      k = c - 1;
      if (c == 0 || c > cplt_c) es = S_IDLE;
      else if (c == cplt_c) es = S_CPLT;
      else if (c <= req_end) es = S_REQ;
      else if (c <= w_c) es = S_LPMD;
      else es = S_EXIT;
      lpmd_if.iui_special_wfi = (c <= cplt_c);
      for (int i = 0; i < NUM_ACK; i++)
        lpmd_if.ack_vec[i] = (es == S_REQ) && (k == a[i] || (lvl[i] && k > a[i]));
      wake_now = (es == S_REQ && outcome == OUT_WAKE && k == w_req) || (es == S_LPMD && c == w_c);
      wake_req = wake_now && !use_dbg;
      dbg_on   = wake_now && use_dbg;
      #1;
      e_stall  = (es == S_IDLE && lpmd_if.iui_special_wfi) || es == S_REQ || es == S_LPMD || es == S_EXIT;
      e_in     = (es == S_LPMD);
      e_lpmd_b = (es == S_LPMD) ? mode : 2'b11;
      e_abort  = (es == S_CPLT) && (outcome == OUT_ABORT);
      for (int i = 0; i < NUM_ACK; i++) e_req[i] = (es == S_REQ) && (k <= a[i]);
      n_checks += 7;
      if (cur_state !== es) begin n_errors++; $display("FAIL %s c%0d state got %b exp %b", name, c, cur_state, es); end
      if (lpmd_b !== e_lpmd_b) begin n_errors++; $display("FAIL %s c%0d lpmd_b got %b exp %b", name, c, lpmd_b, e_lpmd_b); end
      if (in_lpmd !== e_in) begin n_errors++; $display("FAIL %s c%0d in_lpmd got %b exp %b", name, c, in_lpmd, e_in); end
      if (clk_en !== !e_in) begin n_errors++; $display("FAIL %s c%0d clk_en got %b exp %b", name, c, clk_en, !e_in); end
      if (lpmd_if.special_iui_stall !== e_stall) begin n_errors++; $display("FAIL %s c%0d stall got %b exp %b", name, c, lpmd_if.special_iui_stall, e_stall); end
      if (lpmd_if.special_iui_abort !== e_abort) begin n_errors++; $display("FAIL %s c%0d abort got %b exp %b", name, c, lpmd_if.special_iui_abort, e_abort); end
      if (lpmd_if.lpmd_req_vec !== e_req) begin n_errors++; $display("FAIL %s c%0d req_vec got %b exp %b", name, c, lpmd_if.lpmd_req_vec, e_req); end
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    regs_lpmd = 2'b00; regs_timeout = 8'd0;
    lpmd_if.iui_special_wfi = 1'b1;
    step();
    lpmd_if.ack_vec = 2'b01;
    step();
    lpmd_if.ack_vec = 2'b00; flush = 1'b1; wake_req = 1'b1;
    #1;
    n_checks++;
    if (cur_state !== S_REQ) begin n_errors++; $display("FAIL flush_pre_state got %b exp %b", cur_state, S_REQ); end
    step();
    idle_inputs();
    #1;
    n_checks += 4;
    if (cur_state !== S_IDLE) begin n_errors++; $display("FAIL flush_req_state got %b exp %b", cur_state, S_IDLE); end
    if (lpmd_if.special_iui_abort !== 1'b0) begin n_errors++; $display("FAIL flush_req_abort got %b exp 0", lpmd_if.special_iui_abort); end
    if (lpmd_b !== 2'b11) begin n_errors++; $display("FAIL flush_req_lpmd_b got %b exp 11", lpmd_b); end
    if (lpmd_if.lpmd_req_vec !== 2'b00) begin n_errors++; $display("FAIL flush_req_vec got %b exp 00", lpmd_if.lpmd_req_vec); end
    lpmd_if.iui_special_wfi = 1'b1;
    step();
    n_checks++;
    if (lpmd_if.lpmd_req_vec !== 2'b11) begin n_errors++; $display("FAIL flush_rearm_req_vec got %b exp 11", lpmd_if.lpmd_req_vec); end
    lpmd_if.ack_vec = 2'b11;
    step();
    lpmd_if.ack_vec = 2'b00; flush = 1'b1;
    step();
    n_checks += 2;
    if (cur_state !== S_LPMD) begin n_errors++; $display("FAIL flush_in_lpmd_state got %b exp %b", cur_state, S_LPMD); end
    if (lpmd_b !== 2'b00) begin n_errors++; $display("FAIL flush_in_lpmd_lpmd_b got %b exp 00", lpmd_b); end
    flush = 1'b0; wake_req = 1'b1;
    step();
    wake_req = 1'b0; flush = 1'b1;
    n_checks++;
    if (cur_state !== S_EXIT) begin n_errors++; $display("FAIL flush_exit_state got %b exp %b", cur_state, S_EXIT); end
    step();
    idle_inputs();
    #1;
    n_checks += 3;
    if (cur_state !== S_IDLE) begin n_errors++; $display("FAIL flush_exit_idle got %b exp %b", cur_state, S_IDLE); end
    if (lpmd_b !== 2'b11) begin n_errors++; $display("FAIL flush_exit_lpmd_b got %b exp 11", lpmd_b); end
    if (lpmd_if.special_iui_abort !== 1'b0) begin n_errors++; $display("FAIL flush_exit_abort got %b exp 0", lpmd_if.special_iui_abort); end
    step();
  endtask

  task automatic test_reset_in_lpmd();
    regs_lpmd = 2'b01; regs_timeout = 8'd3;
    lpmd_if.iui_special_wfi = 1'b1;
    step();
    n_checks++;
    if (cur_state !== S_REQ) begin n_errors++; $display("FAIL rstlp_req got %b exp %b", cur_state, S_REQ); end
    lpmd_if.ack_vec = 2'b11;
    step();
    lpmd_if.ack_vec = 2'b00;
    #1;
    n_checks += 3;
    if (cur_state !== S_LPMD) begin n_errors++; $display("FAIL rstlp_lpmd got %b exp %b", cur_state, S_LPMD); end
    if (lpmd_b !== 2'b01) begin n_errors++; $display("FAIL rstlp_lpmd_b got %b exp 01", lpmd_b); end
    if (clk_en !== 1'b0) begin n_errors++; $display("FAIL rstlp_clk_en_low got %b exp 0", clk_en); end
    cpurst = 1'b1;
    step();
    cpurst = 1'b0;
    lpmd_if.iui_special_wfi = 1'b0;
    #1;
    n_checks += 4;
    if (cur_state !== S_IDLE) begin n_errors++; $display("FAIL rstlp_state got %b exp %b", cur_state, S_IDLE); end
    if (lpmd_b !== 2'b11) begin n_errors++; $display("FAIL rstlp_lpmd_b_run got %b exp 11", lpmd_b); end
    if (clk_en !== 1'b1) begin n_errors++; $display("FAIL rstlp_clk_en got %b exp 1", clk_en); end
    if (in_lpmd !== 1'b0) begin n_errors++; $display("FAIL rstlp_in_lpmd got %b exp 0", in_lpmd); end
    step();
  endtask

  task automatic test_back_to_back();
    int t, x0, x1, w;
    for (int n = 0; n < 40; n++) begin
      t  = $urandom_range(0, 8);
      x0 = ($urandom_range(0, 3) == 0 && t != 0) ? NEVER : $urandom_range(0, 6);
      x1 = ($urandom_range(0, 3) == 0 && t != 0) ? NEVER : $urandom_range(0, 6);
      w  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      test_scenario("random", 2'($urandom_range(0, 3)), t, x0, x1, w,
                    $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_scenario("simple_entry_exit", 2'b10, 0, 0, 2, -1, 6, 1'b0);
    test_scenario("ack_timeout", 2'b01, 5, 0, NEVER, -1, 0, 1'b0);
    test_scenario("timeout_one", 2'b00, 1, NEVER, 0, -1, 0, 1'b0);
    test_scenario("wake_in_req", 2'b00, 0, 3, 4, 1, 0, 1'b0);
    test_scenario("dbg_in_lpmd", 2'b01, 7, 0, 0, -1, 2, 1'b1);
    test_scenario("ack_at_timeout", 2'b10, 4, 3, 1, -1, 1, 1'b0);
    test_scenario("nop_wfi", 2'b11, 0, 0, 0, -1, 0, 1'b0);
    test_flush();
    test_reset_in_lpmd();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
